qspi_sram_responder: RTL
========================

// Module: qspi_sram_responder
// PURPOSE
//  Device-side (responder) end of the quad-SPI serial SRAM link driven by spi_sram_encoder.
//  Decodes SQI READ/WRITE transactions from the sram_* pins and services them from a generic synchronous memory port.
//  Used as the on-chip/FPGA stand-in for the external RAM/ROM/VRAM chips and as the bench model for encoder regressions.
// PARAMETERS
//  WORD_WIDTH     16  data word width in bits; multiple of 4; nibbles per word NW = WORD_WIDTH/4
//  ADDRESS_WIDTH  15  memory word-address width; taken from addr field bits [ADDRESS_WIDTH-1:0]
// PORTS
//  clk          in   1              system clock; all logic on posedge
//  reset_n      in   1              asynchronous, active-low reset
//  sram_cs_n    in   1              chip select from initiator, active low
//  sram_sck     in   1              serial clock from initiator (async to clk, oversampled)
//  sram_sio_i   in   4              SIO[3:0] driven by initiator
//  sram_sio_o   out  4              SIO[3:0] driven toward initiator
//  sram_sio_oe  out  1              1 = responder drives SIO
//  mem_addr     out  ADDRESS_WIDTH  word address to backing memory
//  mem_wdata    out  WORD_WIDTH     write data
//  mem_we       out  1              one-clk write strobe
//  mem_re       out  1              one-clk read strobe
//  mem_rdata    in   WORD_WIDTH     read data, valid exactly 1 clk after mem_re
//  cmd_error    out  1              one-clk pulse: unsupported command byte received
// BEHAVIOUR
//  Sync: cs_n, sck, sio_i through 2-flop synchronizers; sck edges detected on synced copy.
//   Requires sck high and low phases each >= 4 clk periods.
//  Sampling: SIO input sampled on sck rising edge; SIO output updated on sck falling edge. MSB nibble first.
//  Frame: cmd 2 nibbles, addr 6 nibbles (24 bits), READ adds 2 dummy nibbles, then data nibbles.
//  Commands: 0x03 READ, 0x02 WRITE; any other -> cmd_error pulse, state IGNORE.
//  FSM: IDLE -> CMD (cs_n fall) -> ADDR (2nd cmd nibble) -> DUMMY (READ) | WRITE (WRITE), after 6th addr nibble
//   DUMMY -> READ after 2nd dummy nibble; READ/WRITE stay until cs_n rises.
//   cs_n high in ANY state -> IDLE within 3 clk; oe=0; nibble counters cleared.
//  READ: mem_re pulsed 1 clk after 6th addr nibble sampled, mem_addr=addr[AW-1:0]; rdata captured into shift reg.
//   oe=0 in CMD/ADDR/DUMMY; oe rises on first sck falling edge in READ, first nibble = word[WW-1:WW-4].
//   When shifting the last nibble of a word, mem_addr+1 is prefetched (mem_re) and loaded on the next falling edge.
//   Burst is continuous; mem_addr wraps 2^ADDRESS_WIDTH-1 -> 0.
//  WRITE: nibbles shifted in; after NW-th nibble, mem_wdata=word, mem_we pulse 1 clk, then mem_addr += 1 (wraps).
//   Partial word at cs_n rise is discarded (no mem_we).
//  mem_we and mem_re never asserted in the same clk; at most one each per word.
//  Reset (async, mid-transaction included): sram_sio_o=0, sram_sio_oe=0, mem_addr=0, mem_wdata=0,
//   mem_we=0, mem_re=0, cmd_error=0, FSM=IDLE; next transaction requires a fresh cs_n falling edge.
//  sck edges while cs_n high are ignored.
// TESTING
//  WRITE 0x02, addr 0x000010, data 0xBEEF -> one mem_we, mem_addr=0x0010, mem_wdata=0xBEEF.
//  Preload [0x10]=0xBEEF,[0x11]=0x1234; READ 0x03 addr 0x10, 2 dummies, 8 nibbles -> SIO B,E,E,F,1,2,3,4; oe=0 until 1st data fall.
//  READ at addr 0x7FFF (AW=15), 2 words -> mem_re addrs 0x7FFF then 0x0000; data matches both.
//  WRITE with 3 data nibbles then cs_n high -> no mem_we; next READ returns prior contents; FSM back in IDLE.
//  Cmd 0x05 -> cmd_error 1-clk pulse, oe stays 0, no mem_re/mem_we until cs_n rises.
//  reset_n low mid-READ burst -> all outputs 0 same cycle; after release, new READ from encoder returns correct data.

Source files
------------

// File: rtl/qspi_sram_responder.sv
// Quad-SPI serial SRAM responder: decodes SQI READ (0x03) / WRITE (0x02) frames from
// oversampled sram_* pins and services them from a synchronous single-port memory.
module qspi_sram_responder #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sram_cs_n,
  input  logic                     sram_sck,
  input  logic [3:0]               sram_sio_i,
  output logic [3:0]               sram_sio_o,
  output logic                     sram_sio_oe,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  output logic                     cmd_error
);

  localparam int NW = WORD_WIDTH / 4;
  localparam int HW = ADDRESS_WIDTH - 4;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRead, StWrite, StIgnore
  } state_e;

  logic                     r_cs_meta, r_cs_sync, r_cs_prev;
  logic                     r_sck_meta, r_sck_sync, r_sck_prev;
  logic [3:0]               r_sio_meta, r_sio_sync;
  state_e                   r_state;
  state_e                   w_state_d;
  logic [7:0]               r_cnt;
  logic [HW-1:0]            r_hdr;
  logic                     r_is_read;
  logic [WORD_WIDTH-1:0]    r_word;
  logic [WORD_WIDTH-1:0]    r_rd_buf;
  logic                     r_rd_pend;
  logic [3:0]               r_sio_o;
  logic                     r_oe;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [WORD_WIDTH-1:0]    r_mem_wdata;
  logic                     r_mem_we, r_mem_re, r_cmd_error;

  logic                     w_rise, w_fall, w_cs_fall, w_bad_cmd, w_cnt_last;
  logic [7:0]               w_cmd;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [WORD_WIDTH-1:0]    w_tx_src;

  // cs sync flops reset to "selected" so a cs_n held low across reset never looks like a new frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_meta  <= 1'b0;
      r_cs_sync  <= 1'b0;
      r_cs_prev  <= 1'b0;
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_sio_meta <= 4'h0;
      r_sio_sync <= 4'h0;
    end else begin
      r_cs_meta  <= sram_cs_n;
      r_cs_sync  <= r_cs_meta;
      r_cs_prev  <= r_cs_sync;
      r_sck_meta <= sram_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_sio_meta <= sram_sio_i;
      r_sio_sync <= r_sio_meta;
    end
  end

  assign w_rise     = r_sck_sync & ~r_sck_prev & ~r_cs_sync;
  assign w_fall     = ~r_sck_sync & r_sck_prev & ~r_cs_sync;
  assign w_cs_fall  = r_cs_prev & ~r_cs_sync;
  assign w_cmd      = {r_hdr[3:0], r_sio_sync};
  assign w_addr     = {r_hdr, r_sio_sync};
  assign w_cnt_last = (r_cnt == 8'(NW - 1));
  assign w_tx_src   = (r_cnt == 8'd0) ? r_rd_buf : r_word;

  always_comb begin
    w_state_d = r_state;
    w_bad_cmd = 1'b0;
    if (r_cs_sync) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (w_cs_fall) w_state_d = StCmd;
        StCmd: begin
          if (w_rise && r_cnt == 8'd1) begin
            if (w_cmd == 8'h03 || w_cmd == 8'h02) begin
              w_state_d = StAddr;
            end else begin
              w_state_d = StIgnore;
              w_bad_cmd = 1'b1;
            end
          end
        end
        StAddr:  if (w_rise && r_cnt == 8'd5) w_state_d = r_is_read ? StDummy : StWrite;
        StDummy: if (w_rise && r_cnt == 8'd1) w_state_d = StRead;
        default: w_state_d = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 8'd0;
      r_hdr       <= '0;
      r_is_read   <= 1'b0;
      r_word      <= '0;
      r_rd_buf    <= '0;
      r_rd_pend   <= 1'b0;
      r_sio_o     <= 4'h0;
      r_oe        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_cmd_error <= w_bad_cmd;
      r_rd_pend   <= r_mem_re;
      if (r_rd_pend) r_rd_buf <= mem_rdata;
      if (r_mem_we) r_mem_addr <= r_mem_addr + ADDRESS_WIDTH'(1);
      if (w_rise && (r_state == StCmd || r_state == StAddr)) begin
        r_hdr <= {r_hdr[HW-5:0], r_sio_sync};
      end

      if (w_state_d != r_state) begin
        r_cnt <= 8'd0;
        if (r_state == StCmd) r_is_read <= (w_cmd == 8'h03);
        if (r_state == StAddr && w_state_d != StIdle) begin
          r_mem_addr <= w_addr;
          r_mem_re   <= r_is_read;
        end
      end else begin
        case (r_state)
          StCmd, StAddr, StDummy: if (w_rise) r_cnt <= r_cnt + 8'd1;
          StWrite: begin
            if (w_rise) begin
              r_word <= {r_word[WORD_WIDTH-5:0], r_sio_sync};
              if (w_cnt_last) begin
                r_cnt       <= 8'd0;
                r_mem_wdata <= {r_word[WORD_WIDTH-5:0], r_sio_sync};
                r_mem_we    <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          StRead: begin
            if (w_fall) begin
              r_sio_o <= w_tx_src[WORD_WIDTH-1 -: 4];
              r_word  <= {w_tx_src[WORD_WIDTH-5:0], 4'h0};
              r_oe    <= 1'b1;
              // Last nibble of the word leaves: prefetch the next address for the next fall
              if (w_cnt_last) begin
                r_cnt      <= 8'd0;
                r_mem_addr <= r_mem_addr + ADDRESS_WIDTH'(1);
                r_mem_re   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          default: r_cnt <= r_cnt;
        endcase
      end

      if (w_state_d != StRead) begin
        r_oe    <= 1'b0;
        r_sio_o <= 4'h0;
      end
    end
  end

  assign sram_sio_o  = r_sio_o;
  assign sram_sio_oe = r_oe;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign mem_re      = r_mem_re;
  assign cmd_error   = r_cmd_error;

endmodule
